alu_seq: RTL

//   Parametrised, handshaked successor of the 4-bit switch ALU. Operands are

---
 rtl/alu_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and 1-bit-per-cycle shifts, result returned on a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             err
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NOT = 4'd2, OP_AND = 4'd3,
                           OP_OR  = 4'd4, OP_XOR = 4'd5, OP_SLT = 4'd6, OP_EQ  = 4'd7,
                           OP_MUL = 4'd8, OP_SHL = 4'd9, OP_SRA = 4'd10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic               accept, is_iter;
    logic [SHAMT_W-1:0] shamt;
    logic [CNT_W-1:0]   cnt;
    logic               mul_q, sra_q;
    logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
    logic [WIDTH-1:0]   mplier, sh, sh_nxt;

    logic [WIDTH:0]     add_full, sub_full;
    logic               add_ovf, sub_ovf;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry, sc_ovf, sc_err;

    assign accept  = in_valid & in_ready;
    assign shamt   = b[SHAMT_W-1:0];
    assign is_iter = (op == OP_MUL) || (((op == OP_SHL) || (op == OP_SRA)) && (shamt != '0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_iter ? CALC : DONE;
            CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle datapath; SUB overflow is judged against ~b, the adder's real operand
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1])  && (add_full[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] == ~b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (op)
            OP_ADD: begin sc_res = add_full[WIDTH-1:0]; sc_carry = add_full[WIDTH]; sc_ovf = add_ovf; end
            OP_SUB: begin sc_res = sub_full[WIDTH-1:0]; sc_carry = sub_full[WIDTH]; sc_ovf = sub_ovf; end
            OP_NOT: sc_res = ~a;
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
            OP_EQ:  sc_res = {{(WIDTH-1){1'b0}}, a == b};
            OP_MUL: sc_res = '0;
            OP_SHL, OP_SRA: sc_res = a;   // only reached with a zero shift amount
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration of the multi-cycle ops
    assign prod_nxt = mplier[0] ? prod + mcand : prod;
    assign sh_nxt   = sra_q ? {sh[WIDTH-1], sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0; mul_q <= 1'b0; sra_q <= 1'b0;
            mcand <= '0; prod <= '0; mplier <= '0; sh <= '0;
            result <= '0; carry <= 1'b0; overflow <= 1'b0;
            zero <= 1'b0; negative <= 1'b0; err <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                mul_q  <= (op == OP_MUL);
                sra_q  <= (op == OP_SRA);
                cnt    <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                sh     <= a;
                if (!is_iter) begin
                    result   <= sc_res;
                    carry    <= sc_carry;
                    overflow <= sc_ovf;
                    err      <= sc_err;
                    zero     <= (sc_res == '0);
                    negative <= sc_res[WIDTH-1];
                end
            end else if (state == CALC) begin
                cnt    <= cnt - CNT_W'(1);
                prod   <= prod_nxt;
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                sh     <= sh_nxt;
                if (cnt == CNT_W'(1)) begin
                    result   <= mul_q ? prod_nxt[WIDTH-1:0] : sh_nxt;
                    carry    <= mul_q && (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                    overflow <= 1'b0;
                    err      <= 1'b0;
                    zero     <= ((mul_q ? prod_nxt[WIDTH-1:0] : sh_nxt) == '0);
                    negative <= mul_q ? prod_nxt[WIDTH-1] : sh_nxt[WIDTH-1];
                end
            end
        end
    end
endmodule
